// File: rtl/oam_dma_bridge.sv
// oam_dma_bridge: CPU bus pass-through with sprite DMA.
// A CPU write to DMA_REG halts the CPU and copies one page to OAM_DATA.
module oam_dma_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA = 16'h2004
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_dout,
  input  logic                  cpu_rw_n,
  output logic [REG_WIDTH-1:0]  cpu_din,
  output logic                  rdy,
  output logic                  dma_active,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [REG_WIDTH-1:0]  bus_dout,
  output logic                  bus_rw_n,
  input  logic [REG_WIDTH-1:0]  bus_din
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [REG_WIDTH-1:0] page;
  logic [7:0]           cnt;
  logic [REG_WIDTH-1:0] data_buf;
  logic                 parity;
  logic                 trigger;

  assign trigger = (state_q == IDLE) && !cpu_rw_n
                   && (cpu_addr == DMA_REG);

  // State, transfer registers and free-running parity
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      page     <= '0;
      cnt      <= '0;
      data_buf <= '0;
      parity   <= 1'b0;
    end else begin
      state_q <= state_d;
      parity  <= ~parity;
      if (trigger) begin
        page <= cpu_dout;
        cnt  <= '0;
      end
      if (state_q == READ)
        data_buf <= bus_din;
      if (state_q == WRITE && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
  end

  // Next state and bus mux
  always_comb begin
    state_d  = state_q;
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_rw_n = cpu_rw_n;
    unique case (state_q)
      IDLE: begin
        if (trigger)
          state_d = HALT;
      end
      HALT: begin
        bus_rw_n = 1'b1;
        state_d  = parity ? ALIGN : READ;
      end
      ALIGN: begin
        bus_rw_n = 1'b1;
        state_d  = READ;
      end
      READ: begin
        bus_addr = {page, cnt};
        bus_rw_n = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        bus_addr = OAM_DATA;
        bus_dout = data_buf;
        bus_rw_n = 1'b0;
        state_d  = (cnt == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy        = (state_q == IDLE);
  assign dma_active = !rdy;
  assign cpu_din    = bus_din;

endmodule

// File: tb/tb_oam_dma_bridge.sv
// tb_oam_dma_bridge: directed stimulus, scoreboard of expected
// DMA reads and OAM writes checked by an independent monitor.
module tb_oam_dma_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw_n;
  logic [7:0]  cpu_din;
  logic        rdy;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_rw_n;
  logic [7:0]  bus_din;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_rd [$];
  logic [7:0]  exp_wr [$];
  int          vec = 0;
  int          errs = 0;
  int          wr_cnt = 0;
  logic [15:0] last_rd = '0;
  logic        saw_zero = 1'b0;
  logic        tb_par = 1'b0;

  oam_dma_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_rw_n   (cpu_rw_n),
    .cpu_din    (cpu_din),
    .rdy        (rdy),
    .dma_active (dma_active),
    .bus_addr   (bus_addr),
    .bus_dout   (bus_dout),
    .bus_rw_n   (bus_rw_n),
    .bus_din    (bus_din)
  );

  always #5 clk = ~clk;

  assign bus_din = mem[bus_addr];

  always @(posedge clk)
    tb_par <= reset ? 1'b0 : ~tb_par;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && dma_active) begin
      if (bus_addr == 16'h0000)
        saw_zero = 1'b1;
      if (!bus_rw_n) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(bus_addr), 32'hFFFF_FFFF);
        end else begin
          chk("oam_addr", 32'(bus_addr), 32'h2004);
          chk("oam_data", 32'(bus_dout), 32'(exp_wr.pop_front()));
        end
      end else if (bus_addr != cpu_addr) begin
        last_rd = bus_addr;
        if (exp_rd.size() == 0)
          chk("unexpected_read", 32'(bus_addr), 32'hFFFF_FFFF);
        else
          chk("src_addr", 32'(bus_addr), 32'(exp_rd.pop_front()));
      end
    end
  end

  task automatic start_dma(input logic [7:0] pg, input logic hp);
    @(negedge clk);
    #2;
    if (tb_par != ~hp) begin
      @(negedge clk);
      #2;
    end
    for (int i = 0; i < 256; i++) begin
      exp_rd.push_back({pg, 8'(i)});
      exp_wr.push_back(mem[{pg, 8'(i)}]);
    end
    cpu_addr = 16'h4014;
    cpu_dout = pg;
    cpu_rw_n = 1'b0;
    #1;
    chk("trig_pass_addr", 32'(bus_addr), 32'h4014);
    chk("trig_pass_rw", 32'(bus_rw_n), 0);
    @(negedge clk);
    #2;
    cpu_rw_n = 1'b1;
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic hp);
    int n;
    start_dma(pg, hp);
    n = 0;
    while (!rdy && n < 2000) begin
      n++;
      @(negedge clk);
      #2;
    end
    chk("rdy_low_cycles", n, 513 + int'(hp));
    chk("rd_queue_left", exp_rd.size(), 0);
    chk("wr_queue_left", exp_wr.size(), 0);
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d,
                           input logic rw);
    @(negedge clk);
    #2;
    cpu_addr = a;
    cpu_dout = d;
    cpu_rw_n = rw;
    #1;
    chk("pt_addr", 32'(bus_addr), 32'(a));
    chk("pt_rw", 32'(bus_rw_n), 32'(rw));
    if (!rw)
      chk("pt_dout", 32'(bus_dout), 32'(d));
    chk("pt_rdy", 32'(rdy), 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++)
      mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0300 + i] = ~8'(i);
      mem[16'hFF00 + i] = 8'(i * 3 + 1);
    end
    mem[16'h0123] = 8'h5A;
    reset    = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_rw_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(rdy), 1);
    chk("reset_active", 32'(dma_active), 0);
    reset = 1'b0;

    bus_cycle(16'h0123, 8'h00, 1'b1);
    chk("read_din", 32'(cpu_din), 32'h5A);
    chk("read_active", 32'(dma_active), 0);

    run_dma(8'h02, 1'b0);
    run_dma(8'h02, 1'b1);

    saw_zero = 1'b0;
    run_dma(8'hFF, 1'b0);
    chk("ff_last_rd", 32'(last_rd), 32'hFFFF);
    chk("ff_no_zero", 32'(saw_zero), 0);
    chk("ff_idle", 32'(rdy), 1);

    wr_cnt = 0;
    start_dma(8'h03, 1'b0);
    n = 0;
    while (wr_cnt < 10 && n < 100) begin
      n++;
      @(negedge clk);
      #2;
    end
    chk("tenth_write", wr_cnt, 10);
    reset = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    #2;
    reset = 1'b0;
    cpu_addr = 16'h0456;
    #1;
    chk("abort_rdy", 32'(rdy), 1);
    chk("abort_active", 32'(dma_active), 0);
    chk("abort_follow", 32'(bus_addr), 32'h0456);
    repeat (20) @(negedge clk);
    chk("no_11th_write", wr_cnt, 10);
    run_dma(8'h03, 1'b1);

    bus_cycle(16'h4015, 8'h77, 1'b0);
    bus_cycle(16'h4014, 8'h00, 1'b1);
    bus_cycle(16'h0010, 8'h00, 1'b1);
    chk("no_dma_active", 32'(dma_active), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
